// File: rtl/fpu_arith_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fpu_arith_arbiter                                               |
// | Shares one FPU multiply/add-sub pair between two round-robin clients,    |
// | with a watchdog that turns a hung unit into an error response.           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fpu_arith_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  op0,
   input  logic [1:0]  op1,
   input  logic [1:0]  rmode0,
   input  logic [1:0]  rmode1,
   input  logic [79:0] a0,
   input  logic [79:0] b0,
   input  logic [79:0] a1,
   input  logic [79:0] b1,
   output logic        grant0,
   output logic        grant1,
   output logic        done0,
   output logic        done1,
   output logic [79:0] resp_result,
   output logic [3:0]  resp_flags,
   output logic        resp_error,
   output logic        mul_enable,
   output logic        add_enable,
   output logic [79:0] unit_a,
   output logic [79:0] unit_b,
   output logic [1:0]  unit_rmode,
   output logic        add_subtract,
   input  logic        mul_done,
   input  logic        add_done,
   input  logic [79:0] mul_result,
   input  logic [79:0] add_result,
   input  logic [3:0]  mul_flags,
   input  logic [3:0]  add_flags
);

   localparam logic [79:0] c_indefinite    = 80'hFFFF_C000_0000_0000_0000;
   localparam logic [3:0]  c_error_flags   = 4'b1000;
   localparam logic [7:0]  c_timeout_limit = 8'(TIMEOUT_CYCLES);
   localparam logic [1:0]  c_op_reserved   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_owner;
   logic        r_last;
   logic [1:0]  r_op;
   logic [79:0] r_a;
   logic [79:0] r_b;
   logic [1:0]  r_rmode;
   logic [7:0]  r_count;
   logic        r_grant0;
   logic        r_grant1;
   logic        r_done0;
   logic        r_done1;
   logic        r_mul_en;
   logic        r_add_en;
   logic [79:0] r_result;
   logic [3:0]  r_flags;
   logic        r_error;

   state_t      w_state_nx;
   logic        w_grant0_nx;
   logic        w_grant1_nx;
   logic        w_done0_nx;
   logic        w_done1_nx;
   logic        w_mul_en_nx;
   logic        w_add_en_nx;
   logic        w_last_nx;
   logic        w_take;
   logic        w_win;
   logic [1:0]  w_win_op;
   logic        w_sel_done;
   logic        w_load_unit;
   logic        w_load_error;
   logic        w_count_clr;
   logic        w_count_inc;

   // Tie goes to whoever did not win last; a lone requester always wins.
   assign w_win      = (req0 && req1) ? ~r_last : req1;
   assign w_win_op   = w_win ? op1 : op0;
   assign w_sel_done = r_op[1] ? mul_done : add_done;

   always_comb begin
      w_state_nx   = r_state;
      w_grant0_nx  = r_grant0;
      w_grant1_nx  = r_grant1;
      w_done0_nx   = 1'b0;
      w_done1_nx   = 1'b0;
      w_mul_en_nx  = 1'b0;
      w_add_en_nx  = 1'b0;
      w_last_nx    = r_last;
      w_take       = 1'b0;
      w_load_unit  = 1'b0;
      w_load_error = 1'b0;
      w_count_clr  = 1'b0;
      w_count_inc  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (req0 || req1) begin
               w_take      = 1'b1;
               w_grant0_nx = ~w_win;
               w_grant1_nx = w_win;
               if (w_win_op == c_op_reserved) begin
                  w_load_error = 1'b1;
                  w_done0_nx   = ~w_win;
                  w_done1_nx   = w_win;
                  w_state_nx   = S_RESPOND;
               end else begin
                  w_state_nx = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            w_mul_en_nx = r_op[1];
            w_add_en_nx = ~r_op[1];
            w_count_clr = 1'b1;
            w_state_nx  = S_WAIT;
         end
         S_WAIT: begin
            if (w_sel_done) begin
               w_load_unit = 1'b1;
               w_done0_nx  = ~r_owner;
               w_done1_nx  = r_owner;
               w_state_nx  = S_RESPOND;
            end else if (r_count == c_timeout_limit) begin
               w_load_error = 1'b1;
               w_done0_nx   = ~r_owner;
               w_done1_nx   = r_owner;
               w_state_nx   = S_RESPOND;
            end else begin
               w_count_inc = 1'b1;
            end
         end
         S_RESPOND: begin
            w_grant0_nx = 1'b0;
            w_grant1_nx = 1'b0;
            w_last_nx   = r_owner;
            w_state_nx  = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_grant0 <= 1'b0;
         r_grant1 <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         r_mul_en <= 1'b0;
         r_add_en <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_last   <= w_last_nx;
         r_grant0 <= w_grant0_nx;
         r_grant1 <= w_grant1_nx;
         r_done0  <= w_done0_nx;
         r_done1  <= w_done1_nx;
         r_mul_en <= w_mul_en_nx;
         r_add_en <= w_add_en_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner  <= 1'b0;
         r_op     <= 2'b00;
         r_a      <= '0;
         r_b      <= '0;
         r_rmode  <= 2'b00;
         r_count  <= 8'd0;
         r_result <= '0;
         r_flags  <= 4'b0000;
         r_error  <= 1'b0;
      end else begin
         if (w_take) begin
            r_owner <= w_win;
            r_op    <= w_win_op;
            r_a     <= w_win ? a1 : a0;
            r_b     <= w_win ? b1 : b0;
            r_rmode <= w_win ? rmode1 : rmode0;
         end
         if (w_count_clr) begin
            r_count <= 8'd0;
         end else if (w_count_inc) begin
            r_count <= r_count + 8'd1;
         end
         if (w_load_unit) begin
            r_result <= r_op[1] ? mul_result : add_result;
            r_flags  <= r_op[1] ? mul_flags : add_flags;
            r_error  <= 1'b0;
         end else if (w_load_error) begin
            r_result <= c_indefinite;
            r_flags  <= c_error_flags;
            r_error  <= 1'b1;
         end
      end
   end

   assign grant0       = r_grant0;
   assign grant1       = r_grant1;
   assign done0        = r_done0;
   assign done1        = r_done1;
   assign resp_result  = r_result;
   assign resp_flags   = r_flags;
   assign resp_error   = r_error;
   assign mul_enable   = r_mul_en;
   assign add_enable   = r_add_en;
   assign unit_a       = r_a;
   assign unit_b       = r_b;
   assign unit_rmode   = r_rmode;
   assign add_subtract = r_op[0];

endmodule
`default_nettype wire

// File: tb/tb_fpu_arith_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fpu_arith_arbiter                                            |
// | Directed bench with stub FPU units and an in-order response scoreboard.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_fpu_arith_arbiter;

   localparam logic [79:0] c_one   = 80'h3FFF_8000_0000_0000_0000;
   localparam logic [79:0] c_two   = 80'h4000_8000_0000_0000_0000;
   localparam logic [79:0] c_three = 80'h4000_C000_0000_0000_0000;
   localparam logic [79:0] c_six   = 80'h4001_C000_0000_0000_0000;
   localparam logic [79:0] c_indef = 80'hFFFF_C000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [1:0]  op0 = 2'b00, op1 = 2'b00, rmode0 = 2'b00, rmode1 = 2'b00;
   logic [79:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        grant0, grant1, done0, done1, resp_error;
   logic [79:0] resp_result, unit_a, unit_b;
   logic [3:0]  resp_flags;
   logic        mul_enable, add_enable, add_subtract;
   logic [1:0]  unit_rmode;
   logic        mul_done, add_done;
   logic [79:0] mul_result, add_result;
   logic [3:0]  mul_flags, add_flags;

   fpu_arith_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .rmode0(rmode0), .rmode1(rmode1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
      .resp_result(resp_result), .resp_flags(resp_flags), .resp_error(resp_error),
      .mul_enable(mul_enable), .add_enable(add_enable),
      .unit_a(unit_a), .unit_b(unit_b), .unit_rmode(unit_rmode),
      .add_subtract(add_subtract),
      .mul_done(mul_done), .add_done(add_done),
      .mul_result(mul_result), .add_result(add_result),
      .mul_flags(mul_flags), .add_flags(add_flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub units: done is seen by the arbiter LAT edges after the edge that sees enable.
   int         add_lat = 2, mul_lat = 3;
   logic       add_hang = 1'b0, arm_inject = 1'b0, inject_mul_done = 1'b0;
   logic [7:0] add_cnt = 8'd0, mul_cnt = 8'd0;

   always @(posedge clk) begin
      if (add_enable) add_cnt <= 8'(add_lat);
      else if (add_cnt != 8'd0) add_cnt <= add_cnt - 8'd1;
      if (mul_enable) mul_cnt <= 8'(mul_lat);
      else if (mul_cnt != 8'd0) mul_cnt <= mul_cnt - 8'd1;
   end

   assign add_done   = (add_cnt == 8'd1) && !add_hang;
   assign mul_done   = (mul_cnt == 8'd1) || inject_mul_done;
   assign add_result = (!add_subtract && unit_a == c_one && unit_b == c_one) ? c_two :
                       ( add_subtract && unit_a == c_three && unit_b == c_one) ? c_two : '0;
   assign mul_result = (unit_a == c_two && unit_b == c_three) ? c_six : '0;
   assign add_flags  = {2'b00, unit_rmode};
   assign mul_flags  = {unit_rmode, 2'b00};

   always @(negedge clk) inject_mul_done = arm_inject && add_enable;

   typedef struct {
      logic        client;
      logic [79:0] result;
      logic [3:0]  flags;
      logic        chk_flags;
      logic        error;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0, bad = 0;
   int   done_cnt = 0, mul_en_cnt = 0, add_en_cnt = 0;
   int   last_add_en_cyc = 0;
   logic last_add_sub = 1'b0;
   logic prev_done0 = 1'b0, prev_done1 = 1'b0, prev_mul = 1'b0, prev_add = 1'b0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h required=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mul_enable) mul_en_cnt++;
      if (add_enable) begin
         add_en_cnt++;
         last_add_en_cyc = cyc;
         last_add_sub = add_subtract;
      end
      chk("grant_exclusive", 80'(grant0 & grant1), 80'd0);
      chk("mul_en_one_cycle", 80'(mul_enable & prev_mul), 80'd0);
      chk("add_en_one_cycle", 80'(add_enable & prev_add), 80'd0);
      if (prev_done0) chk("grant0_drop_after_done", 80'(grant0), 80'd0);
      if (prev_done1) chk("grant1_drop_after_done", 80'(grant1), 80'd0);
      if (done0 || done1) begin
         done_cnt++;
         chk("single_done", 80'(done0 & done1), 80'd0);
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_done observed=done0:%0d,done1:%0d required=no_done", done0, done1);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_client", 80'(done1), 80'(e.client));
            chk("grant_held_with_done", 80'(e.client ? grant1 : grant0), 80'd1);
            chk("resp_result", resp_result, e.result);
            if (e.chk_flags) chk("resp_flags", 80'(resp_flags), 80'(e.flags));
            chk("resp_error", 80'(resp_error), 80'(e.error));
         end
      end
      prev_done0 = done0;
      prev_done1 = done1;
      prev_mul   = mul_enable;
      prev_add   = add_enable;
   end

   task automatic wait_done(input logic client, output int dcyc);
      bit seen = 0;
      dcyc = -1;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (client ? done1 : done0) begin
            seen = 1;
            dcyc = cyc;
         end
      end
      total++;
      assert (seen) else begin
         bad++;
         $error("FAIL done_wait client=%0d observed=no_done required=done", client);
      end
   endtask

   // Issues one request at a negedge, holds it until its done, returns req-to-done edges.
   task automatic do_op(input logic client, input logic [1:0] op, input logic [1:0] rm,
                        input logic [79:0] a, input logic [79:0] b,
                        input logic [79:0] xr, input logic [3:0] xf, input logic xcf,
                        input logic xe, output int lat, output int dcyc);
      int start;
      sb.push_back('{client, xr, xf, xcf, xe});
      if (client) begin op1 = op; rmode1 = rm; a1 = a; b1 = b; req1 = 1'b1; end
      else        begin op0 = op; rmode0 = rm; a0 = a; b0 = b; req0 = 1'b1; end
      start = cyc;
      wait_done(client, dcyc);
      req0 = 1'b0;
      req1 = 1'b0;
      lat = dcyc - start;
      repeat (2) @(negedge clk);
   endtask

   int lat, dcyc, m0, a0c, base;
   bit seen;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_grant0", 80'(grant0), 80'd0);
      chk("rst_grant1", 80'(grant1), 80'd0);
      chk("rst_done", 80'({done0, done1}), 80'd0);
      chk("rst_enables", 80'({mul_enable, add_enable}), 80'd0);
      chk("rst_result", resp_result, 80'd0);
      chk("rst_flags_err", 80'({resp_flags, resp_error}), 80'd0);
      chk("rst_unit_ops", {unit_a[77:0], unit_rmode}, 80'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Tie: first winner is client 0 after reset, then strict alternation.
      for (int i = 0; i < 4; i++)
         sb.push_back('{logic'(i % 2), c_two, (i % 2) ? 4'b0010 : 4'b0001, 1'b1, 1'b0});
      op0 = 2'b00; rmode0 = 2'b01; a0 = c_one; b0 = c_one;
      op1 = 2'b00; rmode1 = 2'b10; a1 = c_one; b1 = c_one;
      base = done_cnt;
      req0 = 1'b1;
      req1 = 1'b1;
      for (int n = 0; n < 400 && done_cnt < base + 4; n++) @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      chk("tie_four_dones", 80'(done_cnt - base), 80'd4);
      repeat (3) @(negedge clk);

      // Multiply: L=3 so req-to-done is 6 edges.
      m0 = mul_en_cnt; a0c = add_en_cnt;
      do_op(1'b0, 2'b10, 2'b00, c_two, c_three, c_six, 4'b0000, 1'b1, 1'b0, lat, dcyc);
      chk("mul_latency", 80'(lat), 80'd6);
      chk("mul_one_enable", 80'(mul_en_cnt - m0), 80'd1);
      chk("mul_no_add_enable", 80'(add_en_cnt - a0c), 80'd0);

      // Subtract on client 1 with a stray mul_done during WAIT.
      m0 = mul_en_cnt;
      arm_inject = 1'b1;
      do_op(1'b1, 2'b01, 2'b11, c_three, c_one, c_two, 4'b0011, 1'b1, 1'b0, lat, dcyc);
      arm_inject = 1'b0;
      chk("sub_latency", 80'(lat), 80'd5);
      chk("sub_select", 80'(last_add_sub), 80'd1);
      chk("sub_no_mul_enable", 80'(mul_en_cnt - m0), 80'd0);

      // Watchdog: add unit hangs, response 17 edges after enable.
      add_hang = 1'b1;
      do_op(1'b0, 2'b00, 2'b00, c_one, c_one, c_indef, 4'b1000, 1'b1, 1'b1, lat, dcyc);
      add_hang = 1'b0;
      chk("wdog_enable_to_done", 80'(dcyc - last_add_en_cyc), 80'd17);
      do_op(1'b0, 2'b00, 2'b01, c_one, c_one, c_two, 4'b0001, 1'b1, 1'b0, lat, dcyc);
      chk("after_wdog_latency", 80'(lat), 80'd5);

      // Reserved op: IDLE straight to RESPOND, no unit touched.
      m0 = mul_en_cnt; a0c = add_en_cnt;
      do_op(1'b0, 2'b11, 2'b00, c_one, c_one, c_indef, 4'b0000, 1'b0, 1'b1, lat, dcyc);
      chk("rsvd_latency", 80'(lat), 80'd1);
      chk("rsvd_no_enables", 80'((mul_en_cnt - m0) + (add_en_cnt - a0c)), 80'd0);

      // Reset while the multiplier is busy; its late done must be ignored.
      op0 = 2'b10; rmode0 = 2'b00; a0 = c_two; b0 = c_three;
      req0 = 1'b1;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (mul_enable) seen = 1;
      end
      chk("rstwait_enable_seen", 80'(seen), 80'd1);
      @(negedge clk);
      req0 = 1'b0;
      base = done_cnt;
      reset = 1'b1;
      #1;
      chk("rstwait_async_grant", 80'({grant0, grant1}), 80'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("rstwait_no_done", 80'(done_cnt - base), 80'd0);
      chk("rstwait_grants_low", 80'({grant0, grant1}), 80'd0);
      do_op(1'b0, 2'b10, 2'b00, c_two, c_three, c_six, 4'b0000, 1'b1, 1'b0, lat, dcyc);
      chk("rstwait_recover_latency", 80'(lat), 80'd6);

      chk("scoreboard_empty", 80'(sb.size()), 80'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
